// File: rtl/frv_gprs_sb.sv
// General-purpose register file with per-register busy scoreboard, banked pair writes and write-to-read bypass.
// Reads are combinational; write, lock, release and flush commit on the next rising edge.
module frv_gprs_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic [AW-1:0]   rs3_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] rs3_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rs3_busy,
  input  logic            lk_valid,
  input  logic            lk_wide,
  input  logic [AW-1:0]   lk_addr,
  output logic            lk_ready,
  input  logic            rd_wen,
  input  logic            rd_wide,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_wdata,
  input  logic [XLEN-1:0] rd_wdata_hi,
  input  logic            flush,
  output logic [AW-1:0]   n_busy
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW-1:0]    n_busy_q, n_busy_d;
  logic [NREGS-1:0] wen, lk_tgt, lk_set;
  logic [XLEN-1:0]  wdat [NREGS];

  // x0 is left out of both target vectors, so it is never written nor locked
  always_comb begin
    wen     = '0;
    lk_tgt  = '0;
    wdat[0] = '0;
    for (int i = 1; i < NREGS; i++) begin
      wen[i]    = rd_wen && (rd_wide ? ((AW'(i) >> 1) == (rd_addr >> 1)) : (AW'(i) == rd_addr));
      lk_tgt[i] = lk_wide ? ((AW'(i) >> 1) == (lk_addr >> 1)) : (AW'(i) == lk_addr);
      wdat[i]   = (rd_wide && i[0]) ? rd_wdata_hi : rd_wdata;
    end
  end

  assign lk_ready = !flush && ((lk_tgt & busy_q & ~wen) == '0);
  assign lk_set   = (lk_valid && lk_ready) ? lk_tgt : '0;
  // Lock is applied after release so a same-cycle lock on a written register wins
  assign busy_d   = flush ? '0 : ((busy_q & ~wen) | lk_set);

  always_comb begin
    n_busy_d = '0;
    for (int i = 0; i < NREGS; i++) n_busy_d = n_busy_d + AW'(busy_d[i]);
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q   <= '0;
      n_busy_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wen[i]) regs_q[i] <= wdat[i];
      end
      busy_q   <= busy_d;
      n_busy_q <= n_busy_d;
    end
  end

  assign n_busy = n_busy_q;

  logic [AW-1:0]   ra    [3];
  logic [XLEN-1:0] rdat  [3];
  logic            rbusy [3];

  assign ra[0] = rs1_addr;
  assign ra[1] = rs2_addr;
  assign ra[2] = rs3_addr;

  // A same-cycle lock is not forwarded: bypassed reads report not-busy
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdat[p]  = regs_q[ra[p]];
      rbusy[p] = busy_q[ra[p]];
      if (BYPASS != 0 && wen[ra[p]]) begin
        rdat[p]  = wdat[ra[p]];
        rbusy[p] = 1'b0;
      end
    end
  end

  assign rs1_data = rdat[0];
  assign rs2_data = rdat[1];
  assign rs3_data = rdat[2];
  assign rs1_busy = rbusy[0];
  assign rs2_busy = rbusy[1];
  assign rs3_busy = rbusy[2];

endmodule
